// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - shares one pipelined multiplier tree between divide and multiply requesters
// Optional ARB_PERF_CNT_EN adds grant/starvation performance counters.
module mul_share_arb #(
    parameter int OPW      = 58,
    parameter int RESW     = 116,
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_req,
    input  logic [OPW-1:0]  div_a,
    input  logic [OPW-1:0]  div_b,
    output logic            div_gnt,
    input  logic            mul_req,
    input  logic [OPW-1:0]  mul_a,
    input  logic [OPW-1:0]  mul_b,
    output logic            mul_gnt,
    input  logic            div_flush,
    output logic [OPW-1:0]  mt_a,
    output logic [OPW-1:0]  mt_b,
    output logic            mt_issue,
    input  logic [RESW-1:0] mt_res,
    output logic            div_res_valid,
    output logic [RESW-1:0] div_res,
    output logic            mul_res_valid,
    output logic [RESW-1:0] mul_res,
    output logic            busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]     perf_div_cnt,
    output logic [31:0]     perf_mul_cnt,
    output logic [15:0]     perf_starve_cnt
`endif
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [WW-1:0]  wait_cnt;
    logic           starve;
    logic           issue_own;
    logic [LAT-1:0] tag_vld;
    logic [LAT-1:0] tag_own;
    logic [LAT-1:0] kill;

    // Grants are masked by reset so nothing is accepted while the pipe is held clear.
    always_comb begin
        div_gnt = 1'b0;
        mul_gnt = 1'b0;
        starve  = 1'b0;
        if (rst_n) begin
            if (div_flush) begin
                mul_gnt = mul_req;
            end else if (mul_req && wait_cnt == WAIT_MAX) begin
                mul_gnt = 1'b1;
                starve  = 1'b1;
            end else if (div_req) begin
                div_gnt = 1'b1;
            end else begin
                mul_gnt = mul_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (mul_req && !mul_gnt) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_a      <= '0;
            mt_b      <= '0;
            mt_issue  <= 1'b0;
            issue_own <= 1'b0;
        end else begin
            mt_issue  <= div_gnt | mul_gnt;
            issue_own <= mul_gnt;
            if (div_gnt) begin
                mt_a <= div_a;
                mt_b <= div_b;
            end else if (mul_gnt) begin
                mt_a <= mul_a;
                mt_b <= mul_b;
            end
        end
    end

    // A flush drops every divide-owned entry as it moves one stage down the pipe.
    assign kill = {LAT{div_flush}} & ~tag_own;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= mt_issue & ~(div_flush & ~issue_own);
            tag_own[0] <= issue_own;
            for (int k = 1; k < LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1] & ~kill[k-1];
                tag_own[k] <= tag_own[k-1];
            end
        end
    end

    assign div_res_valid = tag_vld[LAT-1] & ~tag_own[LAT-1] & ~div_flush;
    assign mul_res_valid = tag_vld[LAT-1] & tag_own[LAT-1];
    assign div_res       = mt_res;
    assign mul_res       = mt_res;
    assign busy          = mt_issue | (|(tag_vld & ~kill));

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_div_cnt    <= '0;
            perf_mul_cnt    <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (div_gnt) perf_div_cnt <= perf_div_cnt + 32'd1;
            if (mul_gnt) perf_mul_cnt <= perf_mul_cnt + 32'd1;
            if (starve)  perf_starve_cnt <= perf_starve_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - directed self-checking bench for mul_share_arb
module tb_mul_share_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         div_req, mul_req, div_flush;
    logic [57:0]  div_a, div_b, mul_a, mul_b;
    logic         div_gnt, mul_gnt;
    logic [57:0]  mt_a, mt_b;
    logic         mt_issue;
    logic [115:0] mt_res;
    logic         div_res_valid, mul_res_valid, busy;
    logic [115:0] div_res, mul_res;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]  perf_div_cnt, perf_mul_cnt;
    logic [15:0]  perf_starve_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_share_arb dut (
        .clk(clk), .rst_n(rst_n),
        .div_req(div_req), .div_a(div_a), .div_b(div_b), .div_gnt(div_gnt),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_gnt(mul_gnt),
        .div_flush(div_flush),
        .mt_a(mt_a), .mt_b(mt_b), .mt_issue(mt_issue), .mt_res(mt_res),
        .div_res_valid(div_res_valid), .div_res(div_res),
        .mul_res_valid(mul_res_valid), .mul_res(mul_res),
        .busy(busy)
`ifdef ARB_PERF_CNT_EN
        , .perf_div_cnt(perf_div_cnt), .perf_mul_cnt(perf_mul_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    // Drives one cycle's inputs just after the edge; outputs are then checked 2ns after the edge.
    task automatic step(input logic dr, input logic mr, input logic fl, input logic [57:0] a,
                        input logic [115:0] res);
        @(posedge clk);
        #1;
        div_req = dr; mul_req = mr; div_flush = fl;
        div_a = a; div_b = a; mul_a = ~a; mul_b = ~a; mt_res = res;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        div_req = 0; mul_req = 0; div_flush = 0;
        div_a = '0; div_b = '0; mul_a = '0; mul_b = '0; mt_res = '0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        div_req = 1; mul_req = 1; div_flush = 0;
        div_a = 58'h5; div_b = 58'h5; mul_a = 58'h7; mul_b = 58'h7; mt_res = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_run++;
        if ({div_gnt, mul_gnt, mt_issue, div_res_valid, mul_res_valid, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 000000",
                     {div_gnt, mul_gnt, mt_issue, div_res_valid, mul_res_valid, busy});
        end
        n_run++;
        if (mt_a !== 58'h0 || mt_b !== 58'h0) begin
            n_fail++;
            $display("FAIL reset_operands got %h/%h want 0/0", mt_a, mt_b);
        end
        do_reset();
    endtask

    task automatic test_single_div();
        logic [57:0] one_s;
        one_s = 58'd1 << 56;
        do_reset();
        step(1, 0, 0, one_s, '0);
        n_run++;
        if (div_gnt !== 1'b1 || mul_gnt !== 1'b0) begin
            n_fail++; $display("FAIL single_gnt got div=%b mul=%b want 1 0", div_gnt, mul_gnt);
        end
        step(0, 0, 0, '0, '0);
        n_run++;
        if (mt_issue !== 1'b1 || mt_a !== one_s || mt_b !== one_s) begin
            n_fail++; $display("FAIL single_issue got %b %h %h want 1 %h %h", mt_issue, mt_a, mt_b, one_s, one_s);
        end
        step(0, 0, 0, '0, '0);
        n_run++;
        if (div_res_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_c2 got valid=%b busy=%b want 0 1", div_res_valid, busy);
        end
        step(0, 0, 0, '0, 116'h1234);
        n_run++;
        if (div_res_valid !== 1'b1 || div_res !== 116'h1234 || mul_res_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_result got v=%b res=%h mv=%b want 1 1234 0", div_res_valid, div_res, mul_res_valid);
        end
        step(0, 0, 0, '0, '0);
        n_run++;
        if (div_res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_done got valid=%b busy=%b want 0 0", div_res_valid, busy);
        end
    endtask

    task automatic test_contention();
        logic exp_mul;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(1, 1, 0, 58'(c), '0);
            exp_mul = (c == 4);
            n_run++;
            if (mul_gnt !== exp_mul || div_gnt !== !exp_mul) begin
                n_fail++; $display("FAIL contention_c%0d got div=%b mul=%b want %b %b", c, div_gnt, mul_gnt, !exp_mul, exp_mul);
            end
            if (c == 5) begin
                n_run++;
                if (mt_a !== ~58'd4) begin
                    n_fail++; $display("FAIL contention_operand got %h want %h", mt_a, ~58'd4);
                end
            end
        end
        step(0, 0, 0, '0, '0);
`ifdef ARB_PERF_CNT_EN
        n_run++;
        if (perf_starve_cnt !== 16'd1 || perf_mul_cnt !== 32'd1 || perf_div_cnt !== 32'd5) begin
            n_fail++; $display("FAIL contention_perf got s=%0d m=%0d d=%0d want 1 1 5", perf_starve_cnt, perf_mul_cnt, perf_div_cnt);
        end
`endif
    endtask

    task automatic test_interleave();
        logic exp_d, exp_m;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c < 6) step(c % 2 == 0, c % 2 == 1, 0, 58'(c), 116'(c + 100));
            else       step(0, 0, 0, '0, 116'(c + 100));
            exp_d = (c >= 3 && c <= 8 && (c - 3) % 2 == 0);
            exp_m = (c >= 3 && c <= 8 && (c - 3) % 2 == 1);
            n_run++;
            if (div_res_valid !== exp_d || mul_res_valid !== exp_m) begin
                n_fail++; $display("FAIL interleave_c%0d got dv=%b mv=%b want %b %b", c, div_res_valid, mul_res_valid, exp_d, exp_m);
            end
            if (exp_m) begin
                n_run++;
                if (mul_res !== 116'(c + 100)) begin
                    n_fail++; $display("FAIL interleave_res_c%0d got %h want %h", c, mul_res, 116'(c + 100));
                end
            end
        end
    endtask

    task automatic test_flush();
        logic exp_busy;
        do_reset();
        step(1, 0, 0, 58'd1, '0);
        step(1, 0, 0, 58'd2, '0);
        for (int c = 2; c < 9; c++) begin
            if (c == 2) step(1, 1, 1, 58'd3, '0);
            else        step(0, 0, 0, '0, '0);
            if (c == 2) begin
                n_run++;
                if (div_gnt !== 1'b0 || mul_gnt !== 1'b1) begin
                    n_fail++; $display("FAIL flush_gnt got div=%b mul=%b want 0 1", div_gnt, mul_gnt);
                end
            end
            exp_busy = (c <= 5);
            n_run++;
            if (div_res_valid !== 1'b0 || mul_res_valid !== (c == 5) || busy !== exp_busy) begin
                n_fail++; $display("FAIL flush_c%0d got dv=%b mv=%b busy=%b want 0 %b %b", c, div_res_valid, mul_res_valid, busy, (c == 5), exp_busy);
            end
        end
`ifdef ARB_PERF_CNT_EN
        n_run++;
        if (perf_div_cnt !== 32'd2 || perf_mul_cnt !== 32'd1) begin
            n_fail++; $display("FAIL flush_perf got d=%0d m=%0d want 2 1", perf_div_cnt, perf_mul_cnt);
        end
`endif
    endtask

    task automatic test_flush_req();
        do_reset();
        step(1, 0, 0, 58'd9, '0);
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        step(1, 0, 1, 58'd8, '0);
        n_run++;
        if (div_gnt !== 1'b0 || div_res_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_req_c3 got gnt=%b dv=%b want 0 0", div_gnt, div_res_valid);
        end
        step(0, 0, 0, '0, '0);
        n_run++;
        if (mt_issue !== 1'b0 || busy !== 1'b0 || div_res_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_req_c4 got issue=%b busy=%b dv=%b want 0 0 0", mt_issue, busy, div_res_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        step(1, 0, 0, 58'd11, '0);
        step(0, 1, 0, 58'd12, '0);
        step(0, 0, 0, '0, '0);
        #1 rst_n = 1'b0;
        #1;
        n_run++;
        if ({div_gnt, mul_gnt, mt_issue, div_res_valid, mul_res_valid, busy} !== 6'b0 || mt_a !== 58'h0) begin
            n_fail++; $display("FAIL reset_mid got %b mt_a=%h want 000000 0",
                               {div_gnt, mul_gnt, mt_issue, div_res_valid, mul_res_valid, busy}, mt_a);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, '0, '0);
            if (div_res_valid || mul_res_valid || busy) seen = 1'b1;
        end
        n_run++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_idle got activity=%b want 0", seen);
        end
        step(1, 0, 0, 58'd13, '0);
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, 116'h77);
        n_run++;
        if (div_res_valid !== 1'b1 || div_res !== 116'h77) begin
            n_fail++; $display("FAIL reset_mid_regrant got dv=%b res=%h want 1 77", div_res_valid, div_res);
        end
    endtask

    initial begin
        test_reset();
        test_single_div();
        test_contention();
        test_interleave();
        test_flush();
        test_flush_req();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
